// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: state type and default timing limits shared by the UART transmit arbiter
package uart_arb_pkg;
   localparam int GAP_CYCLES_DEF  = 16;
   localparam int STALL_LIMIT_DEF = 1024;
   typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_DONE, GAP} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          vld
);
   always_comb begin
      idx = '0;
      vld = 1'b0;
      // walk from farthest to nearest so the nearest hit wins
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            idx = IW'((int'(ptr) + i) % N);
            vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between packet requesters with round-robin
// packet-level grants, inter-packet gap and stall-timeout abort
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 2,
   parameter  int GAP_CYCLES  = GAP_CYCLES_DEF,
   parameter  int STALL_LIMIT = STALL_LIMIT_DEF,
   localparam int IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0][7:0] req_data,
   input  logic [NUM_REQ-1:0]      req_last,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [7:0]              tx_in,
   output logic                    tx_start,
   input  logic                    tx_done_tick,
   output logic [IW-1:0]           grant_id,
   output logic                    busy,
   output logic                    err_abort
);
   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   arb_state_e    state_q, state_d;
   logic [IW-1:0] grant_q, grant_d, ptr_q, ptr_d, arb_idx, ptr_nxt;
   logic [SW-1:0] stall_q, stall_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    tx_in_q, tx_in_d;
   logic          last_q, last_d, arb_vld;
   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .idx (arb_idx),
      .vld (arb_vld)
   );
   assign ptr_nxt  = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
   assign grant_id = grant_q;
   assign tx_in    = tx_in_q;
   assign busy     = (state_q == FETCH) || (state_q == START) || (state_q == WAIT_DONE);
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      stall_d   = stall_q;
      gap_d     = gap_q;
      tx_in_d   = tx_in_q;
      last_d    = last_q;
      req_ready = '0;
      tx_start  = 1'b0;
      err_abort = 1'b0;
      case (state_q)
         IDLE: if (arb_vld) begin
            grant_d = arb_idx;
            stall_d = '0;
            state_d = FETCH;
         end
         FETCH: if (req_valid[grant_q]) begin
            req_ready[grant_q] = 1'b1;
            tx_in_d            = req_data[grant_q];
            last_d             = req_last[grant_q];
            stall_d            = '0;
            state_d            = START;
         end else if (int'(stall_q) + 1 >= STALL_LIMIT) begin
            err_abort = 1'b1;
            stall_d   = '0;
            gap_d     = '0;
            ptr_d     = ptr_nxt;
            state_d   = GAP;
         end else begin
            stall_d = stall_q + 1'b1;
         end
         START: begin
            tx_start = 1'b1;
            state_d  = WAIT_DONE;
         end
         WAIT_DONE: if (tx_done_tick) begin
            gap_d   = '0;
            ptr_d   = last_q ? ptr_nxt : ptr_q;
            state_d = last_q ? GAP : FETCH;
         end
         GAP: begin
            gap_d   = (int'(gap_q) + 1 >= GAP_CYCLES) ? gap_q : gap_q + 1'b1;
            state_d = (int'(gap_q) + 1 >= GAP_CYCLES) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         stall_q <= '0;
         gap_q   <= '0;
         tx_in_q <= 8'h00;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         stall_q <= stall_d;
         gap_q   <= gap_d;
         tx_in_q <= tx_in_d;
         last_q  <= last_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized packet traffic against a queue-based requester/transmitter
// model; each scenario task checks the logged byte, grant and timing events
module tb_uart_tx_arbiter;
   import uart_arb_pkg::*;
   localparam int GAP = GAP_CYCLES_DEF, STALL = STALL_LIMIT_DEF, TXD = 10;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] req_valid = '0, req_last = '0, req_ready;
   logic [1:0][7:0] req_data = '0;
   logic [7:0] tx_in;
   logic tx_start, tx_done_tick = 1'b0, busy, err_abort;
   logic [0:0] grant_id;
   typedef struct {int cyc; int id; logic [7:0] d; logic l;} ev_t;
   ev_t rdy_log[$], st_log[$];
   int tick_log[$], abort_log[$];
   bit busy_h[$];
   logic [8:0] rq[2][$];
   int stall_left[2], stall_arm[2];
   int done_cnt = 0, cyc = 0, odd_ready = 0, total = 0, bad = 0;
   bit extra_tick = 0;

   uart_tx_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_in(tx_in), .tx_start(tx_start), .tx_done_tick(tx_done_tick),
      .grant_id(grant_id), .busy(busy), .err_abort(err_abort)
   );

   always #5 clk = ~clk;

   // one clock of the requester queues and a transmitter that finishes TXD cycles after tx_start
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = rq[i].size() > 0 && stall_left[i] == 0;
         req_data[i]  = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
         req_last[i]  = rq[i].size() > 0 ? rq[i][0][8] : 1'b0;
      end
      tx_done_tick = done_cnt == 1 || extra_tick;
      #1;
      busy_h.push_back(busy);
      if (tx_done_tick) tick_log.push_back(cyc);
      if (err_abort) abort_log.push_back(cyc);
      if (tx_start) st_log.push_back('{cyc, int'(grant_id), tx_in, 1'b0});
      if ((req_ready & ~req_valid) != 2'b00 || req_ready == 2'b11) odd_ready++;
      for (int i = 0; i < 2; i++) begin
         if (req_ready[i] && req_valid[i]) begin
            rdy_log.push_back('{cyc, i, req_data[i], req_last[i]});
            void'(rq[i].pop_front());
            if (stall_arm[i] > 0) begin
               stall_left[i] = stall_arm[i];
               stall_arm[i]  = 0;
            end
         end else if (stall_left[i] > 0) stall_left[i]--;
      end
      if (done_cnt > 0) done_cnt--;
      if (tx_start) done_cnt = TXD;
      extra_tick = 0;
      cyc++;
   endtask

   task automatic clear_logs();
      rdy_log.delete(); st_log.delete(); tick_log.delete(); abort_log.delete(); busy_h.delete();
      cyc = 0; odd_ready = 0;
   endtask

   task automatic do_reset();
      rq[0].delete(); rq[1].delete();
      stall_left = '{0, 0}; stall_arm = '{0, 0};
      done_cnt = 0; extra_tick = 0;
      rst = 1'b1; step(); step(); rst = 1'b0;
      clear_logs();
   endtask

   task automatic run_idle(input int budget, output bit to);
      to = 1;
      for (int k = 0; k < budget; k++) begin
         step();
         if (rq[0].size() == 0 && rq[1].size() == 0 && done_cnt == 0 && !busy) begin
            to = 0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      total += 6;
      if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
      if (tx_in !== 8'h00) begin bad++; $display("FAIL rst_tx_in got=%h exp=00", tx_in); end
      if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
      if (grant_id !== 1'b0) begin bad++; $display("FAIL rst_grant got=%b exp=0", grant_id); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (err_abort !== 1'b0) begin bad++; $display("FAIL rst_abort got=%b exp=0", err_abort); end
   endtask

   task automatic test_three_bytes();
      logic [7:0] exp[3] = '{8'hA1, 8'hA2, 8'hA3};
      bit to;
      do_reset();
      rq[0] = '{9'h0A1, 9'h0A2, 9'h1A3};
      run_idle(300, to);
      total += 2;
      if (to) begin bad++; $display("FAIL three_timeout got=1 exp=0"); end
      if (st_log.size() != 3) begin bad++; $display("FAIL three_starts got=%0d exp=3", st_log.size()); end
      if (st_log.size() == 3 && rdy_log.size() == 3 && tick_log.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            total += 3;
            if (st_log[k].d !== exp[k]) begin bad++; $display("FAIL three_byte%0d got=%h exp=%h", k, st_log[k].d, exp[k]); end
            if (st_log[k].id != 0) begin bad++; $display("FAIL three_gid%0d got=%0d exp=0", k, st_log[k].id); end
            if (st_log[k].cyc != rdy_log[k].cyc + 1) begin bad++; $display("FAIL three_rdy2start%0d got=%0d exp=%0d", k, st_log[k].cyc, rdy_log[k].cyc + 1); end
         end
         for (int k = 0; k < 2; k++) begin
            total++;
            if (rdy_log[k+1].cyc != tick_log[k] + 1) begin bad++; $display("FAIL three_done2rdy%0d got=%0d exp=%0d", k, rdy_log[k+1].cyc, tick_log[k] + 1); end
         end
         total += 2;
         if (busy_h[tick_log[2]] !== 1'b1) begin bad++; $display("FAIL three_busy_at_done got=0 exp=1"); end
         if (busy_h[tick_log[2] + 1] !== 1'b0) begin bad++; $display("FAIL three_busy_after got=1 exp=0"); end
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         ev_t exp[$];
         int end_idx[4];
         bit to;
         do_reset();
         // requester p%2 owns packet p; both stay valid, so grants must alternate 0,1,0,1
         for (int p = 0; p < 4; p++) begin
            int len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
               logic [7:0] d = 8'($urandom);
               rq[p % 2].push_back({b == len - 1, d});
               exp.push_back('{0, p % 2, d, b == len - 1});
            end
            end_idx[p] = exp.size() - 1;
         end
         run_idle(800, to);
         total += 3;
         if (to) begin bad++; $display("FAIL b2b_timeout got=1 exp=0"); end
         if (odd_ready != 0) begin bad++; $display("FAIL b2b_ready_shape got=%0d exp=0", odd_ready); end
         if (st_log.size() != exp.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", st_log.size(), exp.size()); end
         if (st_log.size() == exp.size() && tick_log.size() == exp.size()) begin
            for (int k = 0; k < exp.size(); k++) begin
               total++;
               if (st_log[k].id != exp[k].id || st_log[k].d !== exp[k].d) begin
                  bad++; $display("FAIL b2b_byte%0d got=%0d/%h exp=%0d/%h", k, st_log[k].id, st_log[k].d, exp[k].id, exp[k].d);
               end
            end
            for (int p = 0; p < 3; p++) begin
               int t = tick_log[end_idx[p]];
               total += 2;
               if (rdy_log[end_idx[p] + 1].cyc != t + GAP + 2) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", p, rdy_log[end_idx[p] + 1].cyc, t + GAP + 2); end
               if (busy_h[t + 1] !== 1'b0) begin bad++; $display("FAIL b2b_busy_gap%0d got=1 exp=0", p); end
            end
         end
      end
   endtask

   task automatic test_no_preempt();
      bit to = 1;
      do_reset();
      for (int b = 0; b < 4; b++) rq[1].push_back({b == 3, 8'($urandom)});
      for (int k = 0; k < 50 && rdy_log.size() == 0; k++) step();
      rq[0] = '{{1'b0, 8'($urandom)}, {1'b1, 8'($urandom)}};
      run_idle(500, to);
      total += 3;
      if (to) begin bad++; $display("FAIL nopre_timeout got=1 exp=0"); end
      if (odd_ready != 0) begin bad++; $display("FAIL nopre_ready_shape got=%0d exp=0", odd_ready); end
      if (rdy_log.size() != 6) begin bad++; $display("FAIL nopre_count got=%0d exp=6", rdy_log.size()); end
      if (rdy_log.size() == 6 && tick_log.size() == 6) begin
         for (int k = 0; k < 6; k++) begin
            total++;
            if (rdy_log[k].id != (k < 4 ? 1 : 0)) begin bad++; $display("FAIL nopre_owner%0d got=%0d exp=%0d", k, rdy_log[k].id, k < 4 ? 1 : 0); end
         end
         total++;
         if (rdy_log[4].cyc != tick_log[3] + GAP + 2) begin bad++; $display("FAIL nopre_gap got=%0d exp=%0d", rdy_log[4].cyc, tick_log[3] + GAP + 2); end
      end
   endtask

   task automatic test_stall();
      bit to;
      do_reset();
      rq[0] = '{9'h031, 9'h032, 9'h133};
      rq[1] = '{9'h144};
      stall_arm[0] = STALL + 21;
      run_idle(2500, to);
      total += 3;
      if (to) begin bad++; $display("FAIL stall_timeout got=1 exp=0"); end
      if (abort_log.size() != 1) begin bad++; $display("FAIL stall_pulses got=%0d exp=1", abort_log.size()); end
      if (rdy_log.size() != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", rdy_log.size()); end
      if (abort_log.size() == 1 && tick_log.size() > 0 && rdy_log.size() == 4) begin
         int dt = abort_log[0] - tick_log[0];
         total += 3;
         if (dt != STALL && dt != STALL + 1) begin bad++; $display("FAIL stall_time got=%0d exp=%0d", dt, STALL); end
         if (busy_h[abort_log[0] + 1] !== 1'b0) begin bad++; $display("FAIL stall_busy got=1 exp=0"); end
         if (rdy_log[1].id != 1) begin bad++; $display("FAIL stall_ptr got=%0d exp=1", rdy_log[1].id); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      rq[0] = '{9'h05A, 9'h15B};
      for (int k = 0; k < 20 && st_log.size() == 0; k++) step();
      step(); step(); step();
      rq[0].delete();
      rst = 1'b1; step(); rst = 1'b0;
      total += 6;
      if (req_ready !== 2'b00) begin bad++; $display("FAIL mid_ready got=%b exp=00", req_ready); end
      if (tx_in !== 8'h00) begin bad++; $display("FAIL mid_tx_in got=%h exp=00", tx_in); end
      if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_tx_start got=%b exp=0", tx_start); end
      if (grant_id !== 1'b0) begin bad++; $display("FAIL mid_grant got=%b exp=0", grant_id); end
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
      if (err_abort !== 1'b0) begin bad++; $display("FAIL mid_abort got=%b exp=0", err_abort); end
      for (int k = 0; k < 40; k++) step();
      total += 3;
      if (tick_log.size() != 1) begin bad++; $display("FAIL mid_tick_seen got=%0d exp=1", tick_log.size()); end
      if (st_log.size() != 1) begin bad++; $display("FAIL mid_reissue got=%0d exp=1", st_log.size()); end
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_late got=1 exp=0"); end
   endtask

   task automatic test_spurious();
      bit to;
      do_reset();
      extra_tick = 1;
      for (int k = 0; k < 6; k++) step();
      total += 2;
      if (st_log.size() != 0) begin bad++; $display("FAIL spur_idle_start got=%0d exp=0", st_log.size()); end
      if (busy !== 1'b0) begin bad++; $display("FAIL spur_idle_busy got=1 exp=0"); end
      rq[0] = '{9'h011, 9'h122};
      stall_arm[0] = 30;
      for (int k = 0; k < 40 && tick_log.size() < 2; k++) step();
      step(); step(); step();
      extra_tick = 1;
      for (int k = 0; k < 4; k++) step();
      total += 3;
      if (st_log.size() != 1) begin bad++; $display("FAIL spur_fetch_start got=%0d exp=1", st_log.size()); end
      if (rdy_log.size() != 1) begin bad++; $display("FAIL spur_fetch_ready got=%0d exp=1", rdy_log.size()); end
      if (busy !== 1'b1) begin bad++; $display("FAIL spur_fetch_busy got=0 exp=1"); end
      run_idle(200, to);
      total += 2;
      if (to) begin bad++; $display("FAIL spur_timeout got=1 exp=0"); end
      if (st_log.size() != 2 || st_log[st_log.size() - 1].d !== 8'h22) begin
         bad++; $display("FAIL spur_tail got=%0d exp=2 starts ending 22", st_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_three_bytes();
      test_back_to_back();
      test_no_preempt();
      test_stall();
      test_reset_mid();
      test_spurious();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 NUM_REQ, default 2: number of packet requesters sharing the UART transmitter.
REQ-002 GAP_CYCLES, default 16: idle clk cycles forced between consecutive packets.
REQ-003 STALL_LIMIT, default 1024: max clk cycles a granted requester may hold req_valid low mid-packet before abort.
REQ-004 clk  input  1: single clock, 100 MHz UART domain; all logic on rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ: per-requester byte available.
REQ-007 req_data  input  NUM_REQ x 8: per-requester byte.
REQ-008 req_last  input  NUM_REQ: byte is final byte of its packet.
REQ-009 req_ready  output  NUM_REQ: byte accepted this cycle (one-hot or zero).
REQ-010 tx_in  output  8: byte to UART transmitter.
REQ-011 tx_start  output  1: one-cycle pulse starting transmission of tx_in.
REQ-012 tx_done_tick  input  1: one-cycle pulse, transmitter finished current byte.
REQ-013 grant_id  output  clog2(NUM_REQ): index of granted requester, valid while busy.
REQ-014 busy  output  1: a packet is owned by a requester.
REQ-015 err_abort  output  1: one-cycle pulse when a packet is aborted by stall timeout.

Function
REQ-016 States IDLE, FETCH, START, WAIT_DONE, GAP; only these.
REQ-017 IDLE: if any req_valid, grant first asserted requester at or after round-robin pointer (wrapping), busy=1, go FETCH same edge; else stay.
REQ-018 FETCH: if req_valid[grant_id], req_ready[grant_id]=1 that cycle, register req_data into tx_in and req_last into last flag, go START; else increment stall counter.
REQ-019 START: tx_start=1 for exactly one cycle, tx_in stable from START until tx_done_tick, go WAIT_DONE.
REQ-020 WAIT_DONE: on tx_done_tick go FETCH if last flag clear, else go GAP; busy stays 1 until GAP entry.
REQ-021 GAP: busy=0, count GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 goes directly to IDLE next cycle.
REQ-022 Round-robin pointer SHALL update to (grant_id+1) mod NUM_REQ on packet completion or abort; simultaneous requests never starve.
REQ-023 Grant SHALL be held for the whole packet; other requesters' req_ready stay 0 regardless of their req_valid.
REQ-024 Stall counter resets on each accepted byte; reaching STALL_LIMIT in FETCH pulses err_abort, releases grant, goes GAP.
REQ-025 tx_done_tick outside WAIT_DONE SHALL be ignored.
REQ-026 Latency: req_ready to tx_start exactly 1 cycle; tx_done_tick of byte n to req_ready of byte n+1 exactly 1 cycle if valid held.
REQ-027 Single-byte packet (req_last on first byte) SHALL be supported.

Reset
REQ-028 rst SHALL force IDLE, pointer=0, stall and gap counters=0, last flag=0 on next edge, including mid-packet.
REQ-029 Reset values: req_ready=0, tx_in=8'h00, tx_start=0, grant_id=0, busy=0, err_abort=0.
REQ-030 An in-flight transmitter byte at reset SHALL not be re-issued; subsequent tx_done_tick ignored.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the state enum type and default values of GAP_CYCLES and STALL_LIMIT.
REQ-032 Round-robin grant computation SHALL be one sub-module rr_arbiter (request vector, pointer in; grant index, grant valid out; combinational).

Verification
REQ-033 Req0 sends 3 bytes 8'hA1,8'hA2,8'hA3(last), tx_done_tick 10 cycles after each tx_start -> three tx_start pulses with those tx_in values, busy low after third done.
REQ-034 Req0 and req1 valid same cycle from reset -> req0 packet first, GAP 16 cycles, then req1; repeated both-valid -> grants alternate 0,1,0,1.
REQ-035 Req1 mid-packet while req0 valid -> req0 req_ready stays 0 until req1 last byte done plus gap.
REQ-036 Granted requester drops req_valid after first byte for 1024 cycles -> err_abort single pulse, busy=0, pointer advances.
REQ-037 rst asserted in WAIT_DONE -> all outputs reset values next cycle, later tx_done_tick produces no tx_start.
REQ-038 Spurious tx_done_tick in IDLE and FETCH -> no state change, no tx_start.
